adder_arbiter: RTL

ADDER_ARBITER -- requirements
Module: adder_arbiter

---
 rtl/adder_arbiter_pkg.sv | 18 +
 rtl/adder_arbiter_adder_cin.sv | 27 ++
 rtl/adder_arbiter.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/adder_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// adder_arbiter_pkg
// Shared definitions for the two-requester adder arbiter: requester count,
// adder slice width, operand width and the FSM state encoding.
// -----------------------------------------------------------------------------
package adder_arbiter_pkg;

    localparam int NUM_REQ = 2;   // number of requesters
    localparam int XLEN    = 32;  // width of the shared adder slice
    localparam int DWIDTH  = 64;  // operand / result width

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXEC_LO = 2'd1,
        EXEC_HI = 2'd2
    } state_t;

endpackage : adder_arbiter_pkg

// File: rtl/adder_arbiter_adder_cin.sv
// -----------------------------------------------------------------------------
// adder_cin
// 32-bit adder with carry-in and carry-out.
//   i_a, i_b : addends
//   i_cin    : carry-in
//   o_sum    : (i_a + i_b + i_cin) mod 2^32
//   o_cout   : carry out of bit 31
// -----------------------------------------------------------------------------
module adder_cin
    import adder_arbiter_pkg::*;
(
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    input  logic            i_cin,
    output logic [XLEN-1:0] o_sum,
    output logic            o_cout
);

    // Appending cin to the LSB of both addends makes bit 0 produce exactly one
    // carry into bit 1 when cin=1, so a plain adder absorbs the carry-in.
    logic [XLEN+1:0] w_full;

    assign w_full = {1'b0, i_a, i_cin} + {1'b0, i_b, i_cin};
    assign o_sum  = w_full[XLEN:1];
    assign o_cout = w_full[XLEN+1];

endmodule : adder_cin

// File: rtl/adder_arbiter.sv
// -----------------------------------------------------------------------------
// adder_arbiter
// Two requesters share one 32-bit adder. A round-robin arbiter accepts one
// request at a time while idle; narrow (32-bit) ops take one adder pass,
// wide (64-bit) ops take two passes chained through a registered carry.
// Each requester owns a response slot that holds its result until accepted.
//   clock, reset_n              : clock, async active-low reset
//   io_req_valid_i/ready_o      : per-requester request handshake
//   io_req{0,1}_{a,b}_i         : 64-bit operands
//   io_req_sub_i / wide_i       : per-requester op select (sub, 64-bit)
//   io_rsp_valid_o/ready_i      : per-requester response handshake
//   io_rsp{0,1}_result_o        : 64-bit results
//   io_rsp_carry_o              : carry-out (sub: 1 = no borrow)
// -----------------------------------------------------------------------------
module adder_arbiter
    import adder_arbiter_pkg::*;
(
    input  logic               clock,
    input  logic               reset_n,
    input  logic [NUM_REQ-1:0] io_req_valid_i,
    output logic [NUM_REQ-1:0] io_req_ready_o,
    input  logic [DWIDTH-1:0]  io_req0_a_i,
    input  logic [DWIDTH-1:0]  io_req1_a_i,
    input  logic [DWIDTH-1:0]  io_req0_b_i,
    input  logic [DWIDTH-1:0]  io_req1_b_i,
    input  logic [NUM_REQ-1:0] io_req_sub_i,
    input  logic [NUM_REQ-1:0] io_req_wide_i,
    output logic [NUM_REQ-1:0] io_rsp_valid_o,
    input  logic [NUM_REQ-1:0] io_rsp_ready_i,
    output logic [DWIDTH-1:0]  io_rsp0_result_o,
    output logic [DWIDTH-1:0]  io_rsp1_result_o,
    output logic [NUM_REQ-1:0] io_rsp_carry_o
);

    state_t              r_state;
    state_t              w_next_state;
    logic                r_ptr;          // requester that wins a tie
    logic [DWIDTH-1:0]   r_a;
    logic [DWIDTH-1:0]   r_b;
    logic                r_sub;
    logic                r_wide;
    logic                r_id;
    logic [XLEN-1:0]     r_lo;
    logic                r_lo_carry;
    logic [NUM_REQ-1:0]  r_rsp_valid;
    logic [NUM_REQ-1:0]  r_rsp_carry;
    logic [DWIDTH-1:0]   r_rsp_result [NUM_REQ];

    logic [NUM_REQ-1:0]  w_elig;
    logic [NUM_REQ-1:0]  w_grant;
    logic                w_accept;
    logic                w_grant_id;
    logic                w_hi;
    logic [XLEN-1:0]     w_add_a;
    logic [XLEN-1:0]     w_b_half;
    logic [XLEN-1:0]     w_add_b;
    logic                w_add_cin;
    logic [XLEN-1:0]     w_sum;
    logic                w_cout;

    // A requester whose slot still holds a result cannot issue, even if that
    // result is being drained this very cycle.
    assign w_elig = io_req_valid_i & ~r_rsp_valid;

    // NOTE: every signal driven here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        w_grant = '0;
        if (r_state == IDLE && reset_n) begin
            case (w_elig)
                2'b01:   w_grant = 2'b01;
                2'b10:   w_grant = 2'b10;
                2'b11:   w_grant = r_ptr ? 2'b10 : 2'b01;
                default: w_grant = '0;
            endcase
        end
    end

    assign w_accept       = |w_grant;
    assign w_grant_id     = w_grant[1];
    assign io_req_ready_o = w_grant;

    // Shared adder: low halves in EXEC_LO, high halves in EXEC_HI. Subtract is
    // A + ~B + 1, with the +1 entering only on the low pass.
    assign w_hi      = (r_state == EXEC_HI);
    assign w_add_a   = w_hi ? r_a[DWIDTH-1:XLEN] : r_a[XLEN-1:0];
    assign w_b_half  = w_hi ? r_b[DWIDTH-1:XLEN] : r_b[XLEN-1:0];
    assign w_add_b   = r_sub ? ~w_b_half : w_b_half;
    assign w_add_cin = w_hi ? r_lo_carry : r_sub;

    adder_cin u_adder (
        .i_a    (w_add_a),
        .i_b    (w_add_b),
        .i_cin  (w_add_cin),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next_state = EXEC_LO;
            EXEC_LO: w_next_state = r_wide ? EXEC_HI : IDLE;
            EXEC_HI: w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments keep every register sampling
    // pre-edge values, so block order cannot change behaviour.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_next_state;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr       <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_sub       <= 1'b0;
            r_wide      <= 1'b0;
            r_id        <= 1'b0;
            r_lo        <= '0;
            r_lo_carry  <= 1'b0;
            r_rsp_valid <= '0;
            r_rsp_carry <= '0;
            // NOTE: the result array is reset, not left uninitialised,
            // because it drives outputs that must read zero during reset.
            for (int i = 0; i < NUM_REQ; i++) r_rsp_result[i] <= '0;
        end else begin
            // Drain first; a response written below overrides in the same edge.
            for (int i = 0; i < NUM_REQ; i++) begin
                if (io_rsp_ready_i[i]) r_rsp_valid[i] <= 1'b0;
            end

            if (w_accept) begin
                r_a    <= w_grant_id ? io_req1_a_i : io_req0_a_i;
                r_b    <= w_grant_id ? io_req1_b_i : io_req0_b_i;
                r_sub  <= io_req_sub_i[w_grant_id];
                r_wide <= io_req_wide_i[w_grant_id];
                r_id   <= w_grant_id;
                r_ptr  <= ~w_grant_id;
            end

            if (r_state == EXEC_LO) begin
                r_lo       <= w_sum;
                r_lo_carry <= w_cout;
                if (!r_wide) begin
                    r_rsp_valid[r_id]  <= 1'b1;
                    r_rsp_result[r_id] <= {{(DWIDTH-XLEN){1'b0}}, w_sum};
                    r_rsp_carry[r_id]  <= w_cout;
                end
            end

            if (r_state == EXEC_HI) begin
                r_rsp_valid[r_id]  <= 1'b1;
                r_rsp_result[r_id] <= {w_sum, r_lo};
                r_rsp_carry[r_id]  <= w_cout;
            end
        end
    end

    assign io_rsp_valid_o   = r_rsp_valid;
    assign io_rsp_carry_o   = r_rsp_carry;
    assign io_rsp0_result_o = r_rsp_result[0];
    assign io_rsp1_result_o = r_rsp_result[1];

endmodule : adder_arbiter
